// File: rtl/muldiv_dispatch_pkg.sv
// Shared constants for the M-extension dispatch stage: decode mask/match,
// funct3 codes, FSM state encoding and writeback error codes.
package mul_div_constants;

    // An instruction belongs to RV32M iff (instr & mask) == match
    localparam logic [31:0] M_EXT_MASK  = 32'hFE00007F;
    localparam logic [31:0] M_EXT_MATCH = 32'h02000033;

    // RV32M funct3 codes; codes below F3_DIV go to the multiplier
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_WB    = 2'b11
    } state_e;

    localparam logic [1:0] WB_ERR_OK      = 2'b00;
    localparam logic [1:0] WB_ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] WB_ERR_TIMEOUT = 2'b10;

    function automatic logic is_m_ext(input logic [31:0] instr);
        return (instr & M_EXT_MASK) == M_EXT_MATCH;
    endfunction

    // DIV group occupies funct3 values 4..7
    function automatic logic is_div_group(input logic [2:0] funct3);
        return funct3 >= F3_DIV;
    endfunction

endpackage

// File: rtl/muldiv_dispatch_timeout_counter.sv
// Cycle counter for the WAIT state: cleared on issue, counts while waiting,
// flags the last permitted cycle.
module muldiv_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;

    // Counter register: clear has priority over counting
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (clear_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if (enable_i) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign expire_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/muldiv_dispatch.sv
// Issue/collect stage between execute and the multiplier/divider units.
// One request in flight; results return on a writeback handshake tagged with rd.
module muldiv_dispatch
    import mul_div_constants::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instruction,
    input  logic [31:0] req_operand_a,
    input  logic [31:0] req_operand_b,
    input  logic [4:0]  req_rd,
    output logic        mult_i_valid,
    input  logic        mult_o_ready,
    input  logic        mult_result_valid,
    input  logic [31:0] mult_result,
    output logic        div_i_valid,
    input  logic        div_o_ready,
    input  logic        div_result_valid,
    input  logic [31:0] div_result,
    output logic [31:0] unit_instruction,
    output logic [31:0] unit_operand_a,
    output logic [31:0] unit_operand_b,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [1:0]  wb_err
);

    state_e      state_q;
    logic        sel_div_q;
    logic [4:0]  rd_q;
    logic [31:0] instr_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic [1:0]  wb_err_q;

    logic        unit_ready_s;
    logic        result_valid_s;
    logic [31:0] result_s;
    logic        cnt_clear_s;
    logic        cnt_en_s;
    logic        expire_s;

    // Only the selected unit's handshake is ever looked at
    assign unit_ready_s   = sel_div_q ? div_o_ready      : mult_o_ready;
    assign result_valid_s = sel_div_q ? div_result_valid : mult_result_valid;
    assign result_s       = sel_div_q ? div_result       : mult_result;

    // Issue strobes follow the unit's ready directly while in ISSUE
    assign mult_i_valid = (state_q == ST_ISSUE) && !sel_div_q && mult_o_ready;
    assign div_i_valid  = (state_q == ST_ISSUE) &&  sel_div_q && div_o_ready;

    // Ready is forced low while reset is held so nothing is taken mid-reset
    assign req_ready = (state_q == ST_IDLE) && !reset;

    assign cnt_clear_s = (state_q == ST_ISSUE) && unit_ready_s;
    assign cnt_en_s    = (state_q == ST_WAIT);

    muldiv_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (cnt_clear_s),
        .enable_i (cnt_en_s),
        .expire_o (expire_s)
    );

    // Dispatch FSM: captures the request, waits for the unit, holds writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sel_div_q  <= 1'b0;
            rd_q       <= 5'd0;
            instr_q    <= 32'd0;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            wb_err_q   <= WB_ERR_OK;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        instr_q   <= req_instruction;
                        op_a_q    <= req_operand_a;
                        op_b_q    <= req_operand_b;
                        rd_q      <= req_rd;
                        sel_div_q <= is_div_group(req_instruction[14:12]);
                        if (is_m_ext(req_instruction)) begin
                            state_q <= ST_ISSUE;
                        end else begin
                            state_q    <= ST_WB;
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= req_rd;
                            wb_data_q  <= 32'd0;
                            wb_err_q   <= WB_ERR_ILLEGAL;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (unit_ready_s) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result in the expiry cycle still counts as success
                    if (result_valid_s) begin
                        state_q    <= ST_WB;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= (rd_q == 5'd0) ? 32'd0 : result_s;
                        wb_err_q   <= WB_ERR_OK;
                    end else if (expire_s) begin
                        state_q    <= ST_WB;
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= 32'd0;
                        wb_err_q   <= WB_ERR_TIMEOUT;
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wb_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign unit_instruction = instr_q;
    assign unit_operand_a   = op_a_q;
    assign unit_operand_b   = op_b_q;
    assign wb_valid         = wb_valid_q;
    assign wb_rd            = wb_rd_q;
    assign wb_data          = wb_data_q;
    assign wb_err           = wb_err_q;

endmodule

// File: doc/muldiv_dispatch.md
Name: muldiv_dispatch

Overview:
Issue/collect stage between the integer pipeline's execute request and the M-extension units (multiplier, divider). Accepts one request at a time, decodes the RV32M funct3, and forwards the instruction and operands to the matching unit with a valid/ready handshake. Captures the unit's result and presents it on a writeback handshake tagged with rd. Flags non-M instructions and units that never respond.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the request is aborted with an error; must be ≥2.
CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
req_valid  in  1  core request valid
req_ready  out  1  block can accept a request
req_instruction  in  32  instruction word
req_operand_a  in  32  rs1 value
req_operand_b  in  32  rs2 value
req_rd  in  5  destination register
mult_i_valid  out  1  issue strobe to the multiplier
mult_o_ready  in  1  multiplier can accept
mult_result_valid  in  1  multiplier result valid
mult_result  in  32  multiplier result
div_i_valid  out  1  issue strobe to the divider
div_o_ready  in  1  divider can accept
div_result_valid  in  1  divider result valid
div_result  in  32  divider result
unit_instruction  out  32  registered instruction, shared by both units
unit_operand_a  out  32  registered operand a
unit_operand_b  out  32  registered operand b
wb_valid  out  1  writeback valid
wb_ready  in  1  writeback consumer ready
wb_rd  out  5  writeback destination
wb_data  out  32  writeback data
wb_err  out  2  00 ok, 01 illegal (non-M), 10 timeout

Behaviour:
- Decode: an instruction is M-extension iff (instr & 0xFE00007F) == 0x02000033. funct3 = instr[14:12]. funct3 < 4 selects MUL group (multiplier). funct3 ≥ 4 selects DIV group (divider).
- FSM states: IDLE, ISSUE, WAIT, WB. Reset enters IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid: register instruction, operands, rd and unit select.
  - M instruction → ISSUE. Non-M instruction → WB with wb_err=01 and wb_data=0.
- ISSUE:
  - The selected x_i_valid = 1 combinationally for every ISSUE cycle in which x_o_ready = 1, and only then.
  - When x_o_ready = 1 → WAIT, with the counter cleared to 0. Otherwise stay in ISSUE; no timeout applies in ISSUE.
- WAIT:
  - x_i_valid = 0. The counter increments each cycle.
  - First cycle with the selected x_result_valid = 1: capture x_result → WB with wb_err=00.
  - The non-selected unit's result_valid is ignored.
  - If counter == TIMEOUT_CYCLES-1 with no result → WB with wb_err=10 and wb_data=0.
  - A result arriving in the same cycle as expiry wins (err=00).
- WB:
  - wb_valid = 1; wb_rd, wb_data and wb_err are held stable until wb_ready.
  - On wb_ready → IDLE. No new request is accepted in the same cycle (req_ready = 0 outside IDLE).
- rd == 0: the flow is unchanged, but wb_data is forced to 0.
- unit_instruction and unit_operand_a/b are registered at acceptance and stable from ISSUE through WAIT.
- Latency, MUL with unit ready, request accepted at cycle T:
  - ISSUE at T+1, with mult_i_valid high at T+1.
  - WAIT from T+2.
  - Result seen at cycle R gives wb_valid at R+1.
- Reset values: req_ready=0 during reset, 1 the cycle after. mult_i_valid=div_i_valid=0, wb_valid=0, wb_rd=0, wb_data=0, wb_err=00. unit_* registers=0, counter=0.
- Reset mid-operation: FSM returns to IDLE next edge and the in-flight request is dropped silently (no writeback). Any late unit result arriving in IDLE is ignored.
- No combinational path from req_* to wb_*. x_i_valid depends combinationally on x_o_ready only.

Decomposition:
- Shared package (mul_div_constants): M-extension match/mask (0xFE00007F / 0x02000033), funct3 codes, FSM state encoding, wb_err codes.
- Optional sub-module muldiv_timeout_counter (clear/enable/expire, CNT_W wide). Everything else stays flat in one module.

Test Plan:
- MUL, a=6, b=7, rd=5, both units always ready, wb_ready=1 → mult_i_valid one cycle at T+1; wb_valid with wb_rd=5, wb_data=42, wb_err=00; div_i_valid never asserted.
- MULHU (funct3=011), a=b=0xFFFFFFFF, model returns 0xFFFFFFFE after 1 cycle → wb_data=0xFFFFFFFE; DIV (funct3=100), a=100, b=7, model returns 14 after 33 cycles → div_i_valid only, wb_data=14.
- mult_o_ready low 5 cycles in ISSUE → remains in ISSUE with mult_i_valid=0, no timeout, issue on the 6th cycle; then wb_ready low 3 cycles at WB → wb_* held stable, req_ready=0 throughout.
- ADD instruction 0x00000033 → no unit strobe, wb_err=01, wb_data=0 one cycle after acceptance; divider model never responds → wb_err=10 exactly TIMEOUT_CYCLES cycles after entering WAIT.
- reset pulsed in WAIT, then a late mult_result_valid → no wb_valid, req_ready=1 after reset; MUL with rd=0 → wb_data=0.
